vector_floating_point_multiply_scheduler: RTL

VECTOR_FLOATING_POINT_MULTIPLY_SCHEDULER -- requirements
Module: vector_floating_point_multiply_scheduler

---
 rtl/dragonfang_pkg.sv | 27 ++
 rtl/vector_floating_point_multiply_arbiter.sv | 11 +
 rtl/vector_floating_point_multiply_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dragonfang_pkg.sv
// Shared types for the vector FP multiply scheduler: FSM state, operation
// control word and the in-flight tracker entry.
package dragonfang_pkg;

    // Tracker beat-index width; wide enough for any practical MAX_BEATS.
    localparam int VFMUL_IDX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } vfmul_sched_state_t;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] rm;
        logic [4:0] vd;
    } execution_vector_t;

    typedef struct packed {
        logic                   vld;
        logic                   src;
        logic [VFMUL_IDX_W-1:0] idx;
        logic                   last;
    } vfmul_sched_entry_t;

endpackage

// File: rtl/vector_floating_point_multiply_arbiter.sv
// Two-requester arbiter. On a tie the requester other than i_ptr wins;
// tying i_ptr high gives fixed priority to requester 0.
module vector_floating_point_multiply_arbiter (
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);

    assign o_grant = (i_valid == 2'b11) ? (i_ptr ? 2'b01 : 2'b10) : i_valid;

endmodule

// File: rtl/vector_floating_point_multiply_scheduler.sv
// Issues multi-beat multiply requests from two requesters into a pipelined
// multiplier and tracks results. VFMUL_SCHEDULER_ROUND_ROBIN_EN: round-robin tie-break.
module vector_floating_point_multiply_scheduler
    import dragonfang_pkg::*;
#(
    parameter  int MUL_LATENCY = 2,
    parameter  int MAX_BEATS   = 8,
    localparam int BEAT_W      = $clog2(MAX_BEATS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_0,
    output logic              req_ready_1,
    input  logic [BEAT_W-1:0] req_beats_0,
    input  logic [BEAT_W-1:0] req_beats_1,
    input  execution_vector_t req_execution_vector_0,
    input  execution_vector_t req_execution_vector_1,
    output logic              issue_valid,
    output execution_vector_t issue_execution_vector,
    output logic [BEAT_W-1:0] issue_beat_index,
    output logic              issue_source,
    input  logic              stall,
    output logic              result_valid,
    output logic              result_source,
    output logic [BEAT_W-1:0] result_beat_index,
    output logic              result_last,
    output logic              busy
);

    localparam logic [BEAT_W-1:0] MAX_B = BEAT_W'(MAX_BEATS);

    vfmul_sched_state_t r_state, w_state_nxt;
    execution_vector_t  r_ev;
    logic               r_src;
    logic [BEAT_W-1:0]  r_beats, r_idx;
    vfmul_sched_entry_t r_trk [MUL_LATENCY];
    vfmul_sched_entry_t w_entry;

    logic              w_issue, w_last_beat, w_can_grant, w_load, w_ptr;
    logic              w_pending, w_inflight;
    logic [1:0]        w_req_vld, w_gnt;
    logic [BEAT_W-1:0] w_gnt_raw, w_gnt_beats;
    execution_vector_t w_gnt_ev;

    assign w_issue     = (r_state == ST_ISSUE) && !stall;
    assign w_last_beat = (r_idx == r_beats - BEAT_W'(1));
    // A new request may enter only once the current one has no beats left.
    assign w_can_grant = !reset && ((r_state != ST_ISSUE) || (w_issue && w_last_beat));
    assign w_req_vld   = {req_valid_1, req_valid_0} & {2{w_can_grant}};

`ifdef VFMUL_SCHEDULER_ROUND_ROBIN_EN
    logic r_ptr;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       r_ptr <= 1'b0;
        else if (|w_gnt) r_ptr <= w_gnt[1];
    end
    assign w_ptr = r_ptr;
`else
    assign w_ptr = 1'b1;
`endif

    vector_floating_point_multiply_arbiter u_arb (
        .i_valid (w_req_vld),
        .i_ptr   (w_ptr),
        .o_grant (w_gnt)
    );

    assign w_gnt_raw   = w_gnt[1] ? req_beats_1 : req_beats_0;
    assign w_gnt_beats = (w_gnt_raw > MAX_B) ? MAX_B : w_gnt_raw;
    assign w_gnt_ev    = w_gnt[1] ? req_execution_vector_1 : req_execution_vector_0;
    // Zero-beat requests complete at the handshake and never load.
    assign w_load      = (|w_gnt) && (w_gnt_beats != '0);

    // The final tracker stage retires this cycle, so it does not hold DRAIN.
    always_comb begin
        w_pending = 1'b0;
        for (int i = 0; i < MUL_LATENCY - 1; i++) w_pending = w_pending | r_trk[i].vld;
    end
    assign w_inflight = w_pending | r_trk[MUL_LATENCY-1].vld;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_load) begin
            w_state_nxt = ST_ISSUE;
        end else begin
            case (r_state)
                ST_ISSUE: if (w_issue && w_last_beat) w_state_nxt = ST_DRAIN;
                ST_DRAIN: if (!w_pending) w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        issue_valid = w_issue;
        req_ready_0 = w_gnt[0];
        req_ready_1 = w_gnt[1];
        busy        = (r_state != ST_IDLE) || w_inflight;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ev    <= '0;
            r_src   <= 1'b0;
            r_beats <= '0;
            r_idx   <= '0;
        end else if (w_load) begin
            r_ev    <= w_gnt_ev;
            r_src   <= w_gnt[1];
            r_beats <= w_gnt_beats;
            r_idx   <= '0;
        end else if (w_issue) begin
            r_idx   <= w_last_beat ? '0 : r_idx + BEAT_W'(1);
        end
    end

    always_comb begin
        w_entry = '0;
        if (w_issue) begin
            w_entry.vld  = 1'b1;
            w_entry.src  = r_src;
            w_entry.idx  = VFMUL_IDX_W'(r_idx);
            w_entry.last = w_last_beat;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_LATENCY; i++) r_trk[i] <= '0;
        end else begin
            r_trk[0] <= w_entry;
            for (int i = 1; i < MUL_LATENCY; i++) r_trk[i] <= r_trk[i-1];
        end
    end

    assign issue_execution_vector = r_ev;
    assign issue_beat_index       = r_idx;
    assign issue_source           = r_src;
    assign result_valid           = r_trk[MUL_LATENCY-1].vld;
    assign result_source          = r_trk[MUL_LATENCY-1].src;
    assign result_beat_index      = BEAT_W'(r_trk[MUL_LATENCY-1].idx);
    assign result_last            = r_trk[MUL_LATENCY-1].last;

endmodule
